puf_eval_ctrl: RTL
==================

# puf_eval_ctrl

Evaluation sequencer between the arbiter PUF AXI4-Lite register file and the arbiter delay-chain fabric. On a start pulse it latches a challenge and produces RESP_W response bits. For each bit it applies a rotated challenge, runs a configurable number of launch/sample races and majority-votes the synchronized arbiter output. Results, status and a stability metric go back to the register file.

## Interface
Parameters:
- CHAL_W, 64, challenge width driven to the delay chains
- RESP_W, 32, response bits produced per start
- VOTE_W, 4, width of vote-count input
- SETTLE_CYC, 8, cycles per recover and per launch phase; must be ≥ 3

Ports:
- ACLK  in  1  single clock for all logic
- ARESET  in  1  asynchronous reset, active-high; all flops clear immediately on assertion
- start  in  1  single-cycle request from register file
- challenge  in  CHAL_W  challenge, sampled only when start is accepted
- n_votes  in  VOTE_W  races per response bit; 0 is treated as 1; sampled when start is accepted
- puf_chal  out  CHAL_W  challenge applied to the delay chains
- puf_launch  out  1  race launch; high during LAUNCH only
- puf_resp  in  1  raw arbiter output, asynchronous to ACLK
- busy  out  1  evaluation in progress
- done  out  1  sticky completion flag
- overrun  out  1  sticky flag: start seen while busy
- response  out  RESP_W  voted response; bit k is the k-th bit evaluated
- unstable_cnt  out  $clog2(RESP_W+1)  count of response bits whose votes were not unanimous

## Operation
- puf_resp passes through a 2-flop synchronizer (sync2). Only the sync2 output is ever sampled.
- States: IDLE, LOAD, RECOVER, LAUNCH, SAMPLE, DECIDE.
- IDLE + start:
  - latch chal_q = challenge and v_eff = max(n_votes, 1)
  - clear response, unstable_cnt, done and overrun
  - set bit index k = 0
  - go to LOAD
- start while busy: ignored, overrun is set to 1, and the running evaluation is unaffected.
- LOAD (1 cycle): puf_chal <= rotate_left(chal_q, k); ones <= 0; vote counter <= 0; go to RECOVER.
- RECOVER (SETTLE_CYC cycles): puf_launch = 0 so the delay lines discharge; go to LAUNCH.
- LAUNCH (SETTLE_CYC cycles): puf_launch = 1; go to SAMPLE.
- SAMPLE (1 cycle):
  - puf_launch = 0
  - ones += sync2
  - vote counter += 1
  - if vote counter < v_eff, go to RECOVER; otherwise go to DECIDE
- DECIDE (1 cycle):
  - response[k] <= (2*ones > v_eff); ties resolve to 0
  - if ones ≠ 0 and ones ≠ v_eff, unstable_cnt += 1
  - if k < RESP_W-1: k += 1 and go to LOAD
  - otherwise: busy <= 0, done <= 1, go to IDLE
- Width rules:
  - ones is VOTE_W bits wide and cannot overflow because ones ≤ v_eff ≤ 2^VOTE_W-1
  - the comparison 2*ones > v_eff is computed at VOTE_W+1 bits
- puf_chal holds its last value in IDLE.
- response and unstable_cnt are held until the next accepted start.
- challenge and n_votes changing while busy have no effect.

## Timing
- Reset values: puf_chal, response, unstable_cnt = 0; puf_launch, busy, done, overrun = 0; state = IDLE; sync2 = 0.
- Start accepted at edge t: busy = 1 and state = LOAD from t+1.
- Per bit: 2 + v_eff*(2*SETTLE_CYC+1) cycles.
- busy stays high for exactly RESP_W*(2 + v_eff*(2*SETTLE_CYC+1)) cycles.
  - Defaults with v_eff = 1: 608 cycles.
- busy falls and done rises on the same edge.
- A start in the same cycle as busy falls is treated as "while busy": ignored, and overrun is set.
- A start in the first IDLE cycle after completion is accepted.
- puf_launch is a clean registered pulse of SETTLE_CYC cycles, preceded by SETTLE_CYC low cycles.
- ARESET asserted mid-operation:
  - puf_launch drops asynchronously and all outputs return to reset values
  - the evaluation is abandoned, not resumed
  - after deassertion the block waits in IDLE for a new start

## Test plan
- Reset: assert ARESET during LAUNCH -> puf_launch and busy fall with no clock edge; all outputs at reset values; a start after release runs a full evaluation.
- puf_resp tied 1, n_votes = 0, defaults -> busy high exactly 608 cycles; response = 0xFFFFFFFF; unstable_cnt = 0; done = 1.
- Model PUF with puf_resp = XOR-reduce of puf_chal, challenge = 0x0123456789ABCDEF -> puf_chal rotates left by k on each LOAD; response matches the model bit-for-bit.
- Noisy PUF with n_votes = 5:
  - per-bit pattern of 3 ones in 5 -> bit 1; 2 ones in 5 -> bit 0; 5 ones in 5 -> bit 1
  - unstable_cnt equals the number of non-unanimous bits
  - with n_votes = 4 and 2 ones -> bit 0 (tie)
- Start while busy at mid-evaluation and on the completion edge -> overrun = 1; response and timing unchanged; next accepted start clears overrun and done.
- Change challenge and n_votes while busy -> no effect on puf_chal, vote count or response.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: evaluation sequencer for the arbiter PUF.
// Latches a challenge on start and produces RESP_W majority-voted response bits.
// For each bit it applies a rotated challenge, runs v_eff recover/launch/sample
// races on the delay chains and votes the synchronized arbiter output.
`timescale 1ns/1ps
module puf_eval_ctrl #(
   parameter int unsigned CHAL_W     = 64,
   parameter int unsigned RESP_W     = 32,
   parameter int unsigned VOTE_W     = 4,
   parameter int unsigned SETTLE_CYC = 8
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic                         start,
   input  logic [CHAL_W-1:0]            challenge,
   input  logic [VOTE_W-1:0]            n_votes,
   output logic [CHAL_W-1:0]            puf_chal,
   output logic                         puf_launch,
   input  logic                         puf_resp,
   output logic                         busy,
   output logic                         done,
   output logic                         overrun,
   output logic [RESP_W-1:0]            response,
   output logic [$clog2(RESP_W+1)-1:0]  unstable_cnt
);

   localparam int unsigned K_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
   localparam int unsigned S_W  = $clog2(SETTLE_CYC);
   localparam int unsigned UC_W = $clog2(RESP_W + 1);

   localparam logic [K_W-1:0] K_LAST = K_W'(RESP_W - 1);
   localparam logic [S_W-1:0] S_LAST = S_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRecover,
      StLaunch,
      StSample,
      StDecide
   } state_e;

   // Registered state
   state_e              r_state;
   logic                r_sync1;
   logic                r_sync2;
   logic [CHAL_W-1:0]   r_chal_rot;   // challenge pre-rotated for the next LOAD
   logic [CHAL_W-1:0]   r_puf_chal;
   logic                r_launch;
   logic                r_busy;
   logic                r_done;
   logic                r_overrun;
   logic [RESP_W-1:0]   r_resp;
   logic [UC_W-1:0]     r_uc;
   logic [K_W-1:0]      r_k;
   logic [VOTE_W-1:0]   r_veff;
   logic [VOTE_W-1:0]   r_ones;
   logic [VOTE_W-1:0]   r_votes;
   logic [S_W-1:0]      r_tmr;

   // Next-state values
   state_e              w_state_nxt;
   logic [CHAL_W-1:0]   w_chal_rot_nxt;
   logic [CHAL_W-1:0]   w_puf_chal_nxt;
   logic                w_launch_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic                w_overrun_nxt;
   logic [RESP_W-1:0]   w_resp_nxt;
   logic [UC_W-1:0]     w_uc_nxt;
   logic [K_W-1:0]      w_k_nxt;
   logic [VOTE_W-1:0]   w_veff_nxt;
   logic [VOTE_W-1:0]   w_ones_nxt;
   logic [VOTE_W-1:0]   w_votes_nxt;
   logic [S_W-1:0]      w_tmr_nxt;

   // Datapath helpers
   logic [VOTE_W-1:0]   w_votes_inc;
   logic [VOTE_W-1:0]   w_ones_inc;
   logic                w_majority;
   logic                w_split;

   // Two-flop synchronizer for the asynchronous arbiter output
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= puf_resp;
         r_sync2 <= r_sync1;
      end
   end

   // Vote arithmetic; the majority compare runs at VOTE_W+1 bits so 2*ones cannot wrap
   always_comb begin
      w_votes_inc = r_votes + VOTE_W'(1);
      w_ones_inc  = r_ones + {{(VOTE_W-1){1'b0}}, r_sync2};
      w_majority  = ({r_ones, 1'b0} > {1'b0, r_veff});
      w_split     = (r_ones != '0) && (r_ones != r_veff);
   end

   // Sequencer next-state and datapath updates
   always_comb begin
      w_state_nxt    = r_state;
      w_chal_rot_nxt = r_chal_rot;
      w_puf_chal_nxt = r_puf_chal;
      w_busy_nxt     = r_busy;
      w_done_nxt     = r_done;
      w_overrun_nxt  = r_overrun;
      w_resp_nxt     = r_resp;
      w_uc_nxt       = r_uc;
      w_k_nxt        = r_k;
      w_veff_nxt     = r_veff;
      w_ones_nxt     = r_ones;
      w_votes_nxt    = r_votes;
      w_tmr_nxt      = r_tmr;

      // Any start outside IDLE, including the final DECIDE cycle, is an overrun
      if (start && (r_state != StIdle)) begin
         w_overrun_nxt = 1'b1;
      end

      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_chal_rot_nxt = challenge;
               w_veff_nxt     = (n_votes == '0) ? VOTE_W'(1) : n_votes;
               w_resp_nxt     = '0;
               w_uc_nxt       = '0;
               w_done_nxt     = 1'b0;
               w_overrun_nxt  = 1'b0;
               w_k_nxt        = '0;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = StLoad;
            end
         end
         StLoad: begin
            // Drive rotate_left(chal, k) and pre-rotate by one for bit k+1
            w_puf_chal_nxt = r_chal_rot;
            w_chal_rot_nxt = {r_chal_rot[CHAL_W-2:0], r_chal_rot[CHAL_W-1]};
            w_ones_nxt     = '0;
            w_votes_nxt    = '0;
            w_tmr_nxt      = '0;
            w_state_nxt    = StRecover;
         end
         StRecover: begin
            if (r_tmr == S_LAST) begin
               w_tmr_nxt   = '0;
               w_state_nxt = StLaunch;
            end else begin
               w_tmr_nxt = r_tmr + S_W'(1);
            end
         end
         StLaunch: begin
            if (r_tmr == S_LAST) begin
               w_tmr_nxt   = '0;
               w_state_nxt = StSample;
            end else begin
               w_tmr_nxt = r_tmr + S_W'(1);
            end
         end
         StSample: begin
            w_ones_nxt  = w_ones_inc;
            w_votes_nxt = w_votes_inc;
            w_state_nxt = (w_votes_inc < r_veff) ? StRecover : StDecide;
         end
         StDecide: begin
            w_resp_nxt[r_k] = w_majority;
            if (w_split) begin
               w_uc_nxt = r_uc + UC_W'(1);
            end
            if (r_k != K_LAST) begin
               w_k_nxt     = r_k + K_W'(1);
               w_state_nxt = StLoad;
            end else begin
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase

      // Launch is registered from the next state so it aligns exactly with LAUNCH
      w_launch_nxt = (w_state_nxt == StLaunch);
   end

   // State register; reset abandons any evaluation in progress
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state    <= StIdle;
         r_chal_rot <= '0;
         r_puf_chal <= '0;
         r_launch   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
         r_resp     <= '0;
         r_uc       <= '0;
         r_k        <= '0;
         r_veff     <= '0;
         r_ones     <= '0;
         r_votes    <= '0;
         r_tmr      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_chal_rot <= w_chal_rot_nxt;
         r_puf_chal <= w_puf_chal_nxt;
         r_launch   <= w_launch_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_overrun  <= w_overrun_nxt;
         r_resp     <= w_resp_nxt;
         r_uc       <= w_uc_nxt;
         r_k        <= w_k_nxt;
         r_veff     <= w_veff_nxt;
         r_ones     <= w_ones_nxt;
         r_votes    <= w_votes_nxt;
         r_tmr      <= w_tmr_nxt;
      end
   end

   // Output mapping
   always_comb begin
      puf_chal     = r_puf_chal;
      puf_launch   = r_launch;
      busy         = r_busy;
      done         = r_done;
      overrun      = r_overrun;
      response     = r_resp;
      unstable_cnt = r_uc;
   end

endmodule
